// File: rtl/program_mem_boot_if.sv
// Fetch and boot-load signal bundle for program_mem_boot.
// The master side drives the fetch address, fetch request and boot bytes.
interface program_mem_boot_if #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [PC_WIDTH-1:0]   pc;
    logic                  fetch_req;
    logic [DATA_WIDTH-1:0] ir;
    logic                  ir_valid;
    logic                  addr_err;
    logic                  load_en;
    logic                  load_strobe;
    logic [7:0]            load_data;
    logic                  busy;
    logic                  load_done;
    logic [PC_WIDTH:0]     load_words;

    modport master (
        output pc, fetch_req, load_en, load_strobe, load_data,
        input  ir, ir_valid, addr_err, busy, load_done, load_words
    );

    modport slave (
        input  pc, fetch_req, load_en, load_strobe, load_data,
        output ir, ir_valid, addr_err, busy, load_done, load_words
    );
endinterface

// File: rtl/program_mem_boot.sv
// Program memory with a byte-serial boot loader and a single-cycle-latency fetch port.
// Loader assembles big-endian words from load_data; fetches are served only while idle.
module program_mem_boot #(
    parameter int unsigned         PC_WIDTH   = 8,
    parameter int unsigned         DATA_WIDTH = 16,
    parameter int unsigned         DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
    input logic               clk,
    input logic               res_n,
    program_mem_boot_if.slave bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [PC_WIDTH:0] DEPTH_W   = (PC_WIDTH + 1)'(DEPTH);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [BW-1:0]     LAST_BYTE = BW'(BYTES - 1);

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e                st_q, st_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [PC_WIDTH:0]     words_q, words_d;
    logic                  lock_q, lock_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  addr_err_q, addr_err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  in_range;
    logic [AW-1:0]         rd_idx;

    assign word_next = (asm_q << 8) | DATA_WIDTH'(bus.load_data);
    assign in_range  = {1'b0, bus.pc} < DEPTH_W;
    assign rd_idx    = bus.pc[AW-1:0];

    always_comb begin
        st_d       = st_q;
        waddr_d    = waddr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        words_d    = words_q;
        lock_d     = lock_q;
        done_d     = 1'b0;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;

        // A completed full load keeps the loader parked until load_en is released.
        if (!bus.load_en) lock_d = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (bus.load_en && !lock_q) begin
                    st_d       = StLoad;
                    waddr_d    = '0;
                    byte_cnt_d = '0;
                    words_d    = '0;
                end else if (bus.fetch_req) begin
                    ir_d       = in_range ? mem[rd_idx] : NOP_WORD;
                    ir_valid_d = 1'b1;
                    addr_err_d = !in_range;
                end
            end
            StLoad: begin
                if (!bus.load_en) begin
                    st_d       = StIdle;
                    done_d     = 1'b1;
                    byte_cnt_d = '0;
                end else if (bus.load_strobe) begin
                    asm_d = word_next;
                    if (byte_cnt_q == LAST_BYTE) begin
                        mem_we     = 1'b1;
                        byte_cnt_d = '0;
                        waddr_d    = waddr_q + AW'(1);
                        words_d    = words_q + (PC_WIDTH + 1)'(1);
                        if (waddr_q == LAST_ADDR) begin
                            st_d   = StIdle;
                            done_d = 1'b1;
                            lock_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            st_q       <= StIdle;
            waddr_q    <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            words_q    <= '0;
            lock_q     <= 1'b0;
            done_q     <= 1'b0;
            ir_q       <= NOP_WORD;
            ir_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            waddr_q    <= waddr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            words_q    <= words_d;
            lock_q     <= lock_d;
            done_q     <= done_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr_q] <= word_next;
    end

    assign bus.ir         = ir_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.busy       = (st_q == StLoad);
    assign bus.load_done  = done_q;
    assign bus.load_words = words_q;
endmodule

// File: tb/tb_program_mem_boot.sv
// Directed bench for program_mem_boot: boot loading, fetch latency, range errors and reset.
module tb_program_mem_boot;
    localparam logic [15:0] NOP = 16'hA5C3;

    logic clk;
    logic res_n;
    int   total = 0;
    int   bad   = 0;

    program_mem_boot_if #(.PC_WIDTH(8), .DATA_WIDTH(16)) bus ();

    program_mem_boot #(
        .PC_WIDTH  (8),
        .DATA_WIDTH(16),
        .DEPTH     (64),
        .NOP_WORD  (NOP)
    ) dut (
        .clk  (clk),
        .res_n(res_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input int k);
        logic [7:0] b;
        b = 8'(k);
        if (k == 0) return 16'h7788;
        if (k == 1) return 16'h01FE;
        return {b, ~b};
    endfunction

    task automatic test_reset();
        res_n = 1'b1;
        #2 res_n = 1'b0;
        #2;
        total++; if (bus.ir !== NOP) begin bad++; $display("FAIL rst_ir got=%h want=%h", bus.ir, NOP); end
        total++; if (bus.ir_valid !== 1'b0) begin bad++; $display("FAIL rst_ir_valid got=%b want=0", bus.ir_valid); end
        total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%b want=0", bus.addr_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.load_done); end
        total++; if (bus.load_words !== 9'd0) begin bad++; $display("FAIL rst_words got=%0d want=0", bus.load_words); end
        @(negedge clk) res_n = 1'b1;
        tick();
    endtask

    task automatic test_load_basic();
        logic [7:0] bytes [4];
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'hAB; bytes[3] = 8'hCD;
        bus.load_en = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            bus.load_strobe = 1'b1;
            bus.load_data   = bytes[i];
            tick();
        end
        bus.load_strobe = 1'b0;
        total++; if (bus.load_words !== 9'd2) begin bad++; $display("FAIL basic_words_busy got=%0d want=2", bus.load_words); end
        bus.load_en = 1'b0;
        tick();
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", bus.load_done); end
        total++; if (bus.load_words !== 9'd2) begin bad++; $display("FAIL basic_words got=%0d want=2", bus.load_words); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", bus.busy); end
        // Fetch issued while load_done is still high must see the fresh data.
        bus.fetch_req = 1'b1;
        bus.pc        = 8'd0;
        tick();
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.load_done); end
        total++; if (bus.ir !== 16'h1234) begin bad++; $display("FAIL basic_ir0 got=%h want=1234", bus.ir); end
        total++; if (bus.ir_valid !== 1'b1) begin bad++; $display("FAIL basic_valid0 got=%b want=1", bus.ir_valid); end
        bus.pc = 8'd1;
        tick();
        total++; if (bus.ir !== 16'hABCD) begin bad++; $display("FAIL basic_ir1 got=%h want=abcd", bus.ir); end
        total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", bus.addr_err); end
        bus.fetch_req = 1'b0;
        tick();
        total++; if (bus.ir_valid !== 1'b0) begin bad++; $display("FAIL basic_nofetch_valid got=%b want=0", bus.ir_valid); end
        total++; if (bus.ir !== 16'hABCD) begin bad++; $display("FAIL basic_hold got=%h want=abcd", bus.ir); end
    endtask

    task automatic test_addr_err();
        bus.fetch_req = 1'b1;
        bus.pc        = 8'd64;
        tick();
        total++; if (bus.ir !== NOP) begin bad++; $display("FAIL err64_ir got=%h want=%h", bus.ir, NOP); end
        total++; if (bus.ir_valid !== 1'b1) begin bad++; $display("FAIL err64_valid got=%b want=1", bus.ir_valid); end
        total++; if (bus.addr_err !== 1'b1) begin bad++; $display("FAIL err64_flag got=%b want=1", bus.addr_err); end
        bus.pc = 8'd63;
        tick();
        total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL err63_flag got=%b want=0", bus.addr_err); end
        bus.pc = 8'd255;
        tick();
        total++; if (bus.addr_err !== 1'b1) begin bad++; $display("FAIL err255_flag got=%b want=1", bus.addr_err); end
        total++; if (bus.ir !== NOP) begin bad++; $display("FAIL err255_ir got=%h want=%h", bus.ir, NOP); end
        bus.fetch_req = 1'b0;
        tick();
        total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.addr_err); end
    endtask

    task automatic test_full_load();
        logic [7:0] k;
        bus.load_en = 1'b1;
        tick();
        for (int i = 0; i < 128; i++) begin
            k               = 8'(i / 2);
            bus.load_strobe = 1'b1;
            bus.load_data   = (i % 2 == 1) ? ~k : k;
            tick();
            if (i == 126) begin
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL full_busy127 got=%b want=1", bus.busy); end
                total++; if (bus.load_words !== 9'd63) begin bad++; $display("FAIL full_words127 got=%0d want=63", bus.load_words); end
            end
        end
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL full_done got=%b want=1", bus.load_done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL full_idle got=%b want=0", bus.busy); end
        total++; if (bus.load_words !== 9'd64) begin bad++; $display("FAIL full_words got=%0d want=64", bus.load_words); end
        bus.load_data = 8'hEE;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL full_lock_busy got=%b want=0", bus.busy); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL full_done_pulse got=%b want=0", bus.load_done); end
        tick();
        total++; if (bus.load_words !== 9'd64) begin bad++; $display("FAIL full_lock_words got=%0d want=64", bus.load_words); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL full_lock_busy2 got=%b want=0", bus.busy); end
        bus.load_strobe = 1'b0;
        bus.load_en     = 1'b0;
        tick();
        bus.fetch_req = 1'b1;
        bus.pc        = 8'd0;
        tick();
        total++; if (bus.ir !== 16'h00FF) begin bad++; $display("FAIL full_ir0 got=%h want=00ff", bus.ir); end
        bus.pc = 8'd63;
        tick();
        total++; if (bus.ir !== 16'h3FC0) begin bad++; $display("FAIL full_ir63 got=%h want=3fc0", bus.ir); end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_partial();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        // Fetch raised in the same cycle load_en enters LOAD is dropped.
        bus.load_en   = 1'b1;
        bus.fetch_req = 1'b1;
        bus.pc        = 8'd0;
        tick();
        total++; if (bus.ir_valid !== 1'b0) begin bad++; $display("FAIL part_enter_valid got=%b want=0", bus.ir_valid); end
        total++; if (bus.ir !== 16'h3FC0) begin bad++; $display("FAIL part_enter_ir got=%h want=3fc0", bus.ir); end
        bus.pc = 8'd5;
        for (int i = 0; i < 3; i++) begin
            bus.load_strobe = 1'b1;
            bus.load_data   = bytes[i];
            tick();
        end
        total++; if (bus.ir_valid !== 1'b0) begin bad++; $display("FAIL part_busy_valid got=%b want=0", bus.ir_valid); end
        total++; if (bus.ir !== 16'h3FC0) begin bad++; $display("FAIL part_busy_ir got=%h want=3fc0", bus.ir); end
        bus.load_strobe = 1'b0;
        bus.fetch_req   = 1'b0;
        bus.load_en     = 1'b0;
        tick();
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL part_done got=%b want=1", bus.load_done); end
        total++; if (bus.load_words !== 9'd1) begin bad++; $display("FAIL part_words got=%0d want=1", bus.load_words); end
        bus.fetch_req = 1'b1;
        bus.pc        = 8'd0;
        tick();
        total++; if (bus.ir !== 16'h1122) begin bad++; $display("FAIL part_ir0 got=%h want=1122", bus.ir); end
        bus.pc = 8'd1;
        tick();
        total++; if (bus.ir !== 16'h01FE) begin bad++; $display("FAIL part_ir1 got=%h want=01fe", bus.ir); end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] bytes [3];
        bytes[0] = 8'h77; bytes[1] = 8'h88; bytes[2] = 8'h99;
        bus.load_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.load_strobe = 1'b1;
            bus.load_data   = bytes[i];
            tick();
        end
        bus.load_strobe = 1'b0;
        #2 res_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
        total++; if (bus.ir !== NOP) begin bad++; $display("FAIL mid_ir got=%h want=%h", bus.ir, NOP); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", bus.load_done); end
        total++; if (bus.load_words !== 9'd0) begin bad++; $display("FAIL mid_words got=%0d want=0", bus.load_words); end
        bus.load_en = 1'b0;
        @(negedge clk) res_n = 1'b1;
        tick();
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL mid_done_after got=%b want=0", bus.load_done); end
        bus.fetch_req = 1'b1;
        bus.pc        = 8'd0;
        tick();
        total++; if (bus.ir !== 16'h7788) begin bad++; $display("FAIL mid_ir0 got=%h want=7788", bus.ir); end
        bus.pc = 8'd1;
        tick();
        total++; if (bus.ir !== 16'h01FE) begin bad++; $display("FAIL mid_ir1 got=%h want=01fe", bus.ir); end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.fetch_req = 1'b1;
        bus.pc        = 8'd0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            total++;
            if (bus.ir !== exp_word(i)) begin
                bad++;
                $display("FAIL b2b_ir pc=%0d got=%h want=%h", i, bus.ir, exp_word(i));
            end
            total++;
            if (bus.ir_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_valid pc=%0d got=%b want=1", i, bus.ir_valid);
            end
            bus.pc = 8'(i + 1);
        end
        bus.fetch_req = 1'b0;
        tick();
        total++; if (bus.ir_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b want=0", bus.ir_valid); end
    endtask

    initial begin
        bus.pc          = '0;
        bus.fetch_req   = 1'b0;
        bus.load_en     = 1'b0;
        bus.load_strobe = 1'b0;
        bus.load_data   = '0;
        test_reset();
        test_load_basic();
        test_addr_err();
        test_full_load();
        test_partial();
        test_reset_mid_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_mem_boot.md
PROGRAM_MEM_BOOT -- requirements
Module: program_mem_boot

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program counter width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, instruction width; integer multiple of 8, minimum 8.
REQ-003 SHALL have parameter DEPTH, default 64, number of instruction words; 1 <= DEPTH <= 2^PC_WIDTH.
REQ-004 SHALL have parameter NOP_WORD, default 0, DATA_WIDTH value returned for out-of-range fetches.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port res_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pc  input  PC_WIDTH  fetch address.
REQ-008 SHALL have port fetch_req  input  1  fetch request, sampled each cycle.
REQ-009 SHALL have port ir  output  DATA_WIDTH  registered instruction word.
REQ-010 SHALL have port ir_valid  output  1  one-cycle pulse, ir updated by a fetch.
REQ-011 SHALL have port addr_err  output  1  one-cycle pulse with ir_valid when pc >= DEPTH.
REQ-012 SHALL have port load_en  input  1  level; requests/holds boot-load mode.
REQ-013 SHALL have port load_strobe  input  1  one byte on load_data this cycle.
REQ-014 SHALL have port load_data  input  8  boot byte.
REQ-015 SHALL have port busy  output  1  high while in LOAD state.
REQ-016 SHALL have port load_done  output  1  one-cycle pulse when a load session ends.
REQ-017 SHALL have port load_words  output  PC_WIDTH+1  words written in last/current session.

Function
REQ-018 SHALL implement states IDLE and LOAD; IDLE -> LOAD when load_en=1; LOAD -> IDLE when load_en=0 or word DEPTH-1 has been written.
REQ-019 On IDLE -> LOAD SHALL clear write address, byte counter and load_words to 0.
REQ-020 In LOAD, each load_strobe SHALL shift load_data into a word assembler, first byte landing in the most significant byte (big-endian).
REQ-021 On the strobe completing DATA_WIDTH/8 bytes SHALL write the word to mem[write address] in that cycle, increment write address and load_words, clear byte counter.
REQ-022 After the write to address DEPTH-1 SHALL return to IDLE next cycle and pulse load_done, regardless of load_en; further strobes ignored until load_en goes 0 and back to 1.
REQ-023 On load_en falling in LOAD SHALL discard any partial word, return to IDLE, pulse load_done; load_words holds count of complete words.
REQ-024 load_strobe in IDLE SHALL be ignored.
REQ-025 In IDLE with fetch_req=1 SHALL register mem[pc] (or NOP_WORD if pc >= DEPTH) into ir, with ir_valid=1 in the following cycle (latency 1).
REQ-026 Back-to-back fetch_req SHALL yield one ir per cycle, ir_valid held high.
REQ-027 Without a fetch ir SHALL hold its last value; ir_valid=0.
REQ-028 fetch_req while busy=1, or in the cycle load_en=1 enters LOAD, SHALL be dropped: no ir update, ir_valid=0 next cycle.
REQ-029 A fetch in the cycle after load_done SHALL return newly written data.
REQ-030 Memory array SHALL be synchronous, one write port (loader) and one read port (fetch); no simultaneous read/write occurs by construction.

Reset
REQ-031 res_n=0 SHALL immediately force: state IDLE, ir=NOP_WORD, ir_valid=0, addr_err=0, busy=0, load_done=0, load_words=0, byte counter and write address 0.
REQ-032 Reset SHALL NOT clear memory contents; content before first load is undefined.
REQ-033 Reset during LOAD SHALL abort the session without load_done; words already written remain.

Verification
REQ-034 Reset, load_en=1, strobe bytes 12,34,AB,CD, load_en=0 -> load_done pulse, load_words=2; fetch pc=0 -> ir=1234, pc=1 -> ir=ABCD, latency 1.
REQ-035 Fetch pc=64 (DEPTH=64) -> ir=NOP_WORD, ir_valid=1, addr_err=1 same cycle.
REQ-036 Load 128 bytes with load_en held high -> load_done after word 63, busy=0, 129th byte ignored; fetch pc=63 returns last word.
REQ-037 Load 3 bytes then drop load_en -> load_words=1, mem[1] unchanged; fetch during busy -> ir_valid=0, ir unchanged.
REQ-038 res_n=0 asynchronously mid-LOAD -> busy=0, ir=NOP_WORD, no load_done; previously written word readable.
REQ-039 fetch_req held high, pc 0..10 one per cycle -> ir sequence mem[0..10], ir_valid continuously 1.
